// File: rtl/snake_engine.sv
// Snake game core: head/body/apple state, a tick-driven step FSM with sequential
// self-collision check and LFSR apple placement, plus a registered per-pixel entity lookup.
module snake_engine #(
  parameter int unsigned GRID_W    = 40,
  parameter int unsigned GRID_H    = 30,
  parameter int unsigned H_SQUARE  = 16,
  parameter int unsigned V_SQUARE  = 16,
  parameter int unsigned MAX_TAILS = 32,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                               vga_clk,
  input  logic                               reset_n,
  input  logic                               tick,
  input  logic [1:0]                         dir_in,
  input  logic                               dir_valid,
  input  logic [9:0]                         x_in,
  input  logic [9:0]                         y_in,
  output logic [1:0]                         entity,
  output logic                               game_over,
  output logic                               game_won,
  output logic [$clog2(MAX_TAILS+1)-1:0]     tail_count,
  output logic                               busy
);

  localparam int unsigned XW = $clog2(GRID_W);
  localparam int unsigned YW = $clog2(GRID_H);
  localparam int unsigned TW = $clog2(MAX_TAILS + 1);

  // Opposite directions differ only in bit 1.
  localparam logic [1:0] LEFT_DIR  = 2'd0;
  localparam logic [1:0] TOP_DIR   = 2'd1;
  localparam logic [1:0] RIGHT_DIR = 2'd2;
  localparam logic [1:0] DOWN_DIR  = 2'd3;

  localparam logic [1:0] ENT_NOTHING    = 2'd0;
  localparam logic [1:0] ENT_SNAKE_HEAD = 2'd1;
  localparam logic [1:0] ENT_SNAKE_TAIL = 2'd2;
  localparam logic [1:0] ENT_APPLE      = 2'd3;

  typedef enum logic [2:0] {StRun, StCheck, StCommit, StPlace, StOver, StWon} state_e;

  state_e        state_q, state_d;
  logic [XW-1:0] head_x_q, apple_x_q, nxt_x_q, cand_x_q, nh_x, lfsr_x;
  logic [YW-1:0] head_y_q, apple_y_q, nxt_y_q, cand_y_q, nh_y, lfsr_y;
  logic [XW-1:0] body_x_q [MAX_TAILS];
  logic [YW-1:0] body_y_q [MAX_TAILS];
  logic [TW-1:0] tail_count_q, idx_q, tc_inc;
  logic [1:0]    cur_dir_q, pend_dir_q, step_dir_q, entity_q, entity_d;
  logic [15:0]   lfsr_q;
  logic          lfsr_fb, eat, chk_hit, place_hit, in_grid, body_px;
  logic [9:0]    cell_x, cell_y;

  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign lfsr_x  = XW'(lfsr_q[7:0] % GRID_W);
  assign lfsr_y  = YW'(lfsr_q[15:8] % GRID_H);
  assign eat     = (nxt_x_q == apple_x_q) && (nxt_y_q == apple_y_q);
  assign tc_inc  = tail_count_q + TW'(eat);

  always_comb begin
    nh_x = head_x_q;
    nh_y = head_y_q;
    unique case (pend_dir_q)
      LEFT_DIR:  nh_x = (head_x_q == '0) ? XW'(GRID_W - 1) : head_x_q - XW'(1);
      RIGHT_DIR: nh_x = (head_x_q == XW'(GRID_W - 1)) ? '0 : head_x_q + XW'(1);
      TOP_DIR:   nh_y = (head_y_q == '0) ? YW'(GRID_H - 1) : head_y_q - YW'(1);
      DOWN_DIR:  nh_y = (head_y_q == YW'(GRID_H - 1)) ? '0 : head_y_q + YW'(1);
    endcase
  end

  // Index 0 of the placement scan is the head, index i+1 is body[i].
  always_comb begin
    chk_hit   = 1'b0;
    place_hit = (idx_q == '0) && (head_x_q == cand_x_q) && (head_y_q == cand_y_q);
    for (int i = 0; i < MAX_TAILS; i++) begin
      if (idx_q == TW'(i) && body_x_q[i] == nxt_x_q && body_y_q[i] == nxt_y_q) chk_hit = 1'b1;
      if (idx_q == TW'(i + 1) && body_x_q[i] == cand_x_q && body_y_q[i] == cand_y_q) begin
        place_hit = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (tick) state_d = StCheck;
      StCheck: begin
        if (tail_count_q == '0)                      state_d = StCommit;
        else if (chk_hit)                            state_d = StOver;
        else if (idx_q == tail_count_q - TW'(1))     state_d = StCommit;
      end
      StCommit: begin
        if (tc_inc == TW'(MAX_TAILS)) state_d = StWon;
        else if (eat)                 state_d = StPlace;
        else                          state_d = StRun;
      end
      StPlace: if (!place_hit && idx_q == tail_count_q) state_d = StRun;
      default: ;
    endcase
  end

  always_ff @(posedge vga_clk) begin
    if (!reset_n) state_q <= StRun;
    else          state_q <= state_d;
  end

  always_comb begin
    cell_x  = 10'(x_in / 10'(H_SQUARE));
    cell_y  = 10'(y_in / 10'(V_SQUARE));
    in_grid = (cell_x < 10'(GRID_W)) && (cell_y < 10'(GRID_H));
    body_px = 1'b0;
    for (int i = 0; i < MAX_TAILS; i++) begin
      if (TW'(i) < tail_count_q && cell_x == 10'(body_x_q[i]) && cell_y == 10'(body_y_q[i])) begin
        body_px = 1'b1;
      end
    end
    entity_d = ENT_NOTHING;
    if (!in_grid)                                                   entity_d = ENT_NOTHING;
    else if (cell_x == 10'(head_x_q) && cell_y == 10'(head_y_q))   entity_d = ENT_SNAKE_HEAD;
    else if (cell_x == 10'(apple_x_q) && cell_y == 10'(apple_y_q)) entity_d = ENT_APPLE;
    else if (body_px)                                               entity_d = ENT_SNAKE_TAIL;
  end

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      head_x_q     <= XW'(GRID_W / 2);
      head_y_q     <= YW'(GRID_H / 2);
      apple_x_q    <= XW'(GRID_W / 2 + GRID_W / 4);
      apple_y_q    <= YW'(GRID_H / 2);
      nxt_x_q      <= '0;
      nxt_y_q      <= '0;
      cand_x_q     <= '0;
      cand_y_q     <= '0;
      tail_count_q <= '0;
      idx_q        <= '0;
      cur_dir_q    <= RIGHT_DIR;
      pend_dir_q   <= RIGHT_DIR;
      step_dir_q   <= RIGHT_DIR;
      lfsr_q       <= LFSR_SEED;
      entity_q     <= ENT_NOTHING;
      for (int i = 0; i < MAX_TAILS; i++) begin
        body_x_q[i] <= '0;
        body_y_q[i] <= '0;
      end
    end else begin
      lfsr_q   <= {lfsr_q[14:0], lfsr_fb};
      entity_q <= entity_d;
      if (dir_valid && dir_in != (cur_dir_q ^ 2'b10)) pend_dir_q <= dir_in;
      unique case (state_q)
        StRun: begin
          if (tick) begin
            idx_q      <= '0;
            nxt_x_q    <= nh_x;
            nxt_y_q    <= nh_y;
            step_dir_q <= pend_dir_q;
          end
        end
        StCheck: idx_q <= idx_q + TW'(1);
        StCommit: begin
          body_x_q[0] <= head_x_q;
          body_y_q[0] <= head_y_q;
          for (int i = 1; i < MAX_TAILS; i++) begin
            body_x_q[i] <= body_x_q[i-1];
            body_y_q[i] <= body_y_q[i-1];
          end
          head_x_q     <= nxt_x_q;
          head_y_q     <= nxt_y_q;
          cur_dir_q    <= step_dir_q;
          tail_count_q <= tc_inc;
          cand_x_q     <= lfsr_x;
          cand_y_q     <= lfsr_y;
          idx_q        <= '0;
        end
        StPlace: begin
          if (place_hit) begin
            cand_x_q <= lfsr_x;
            cand_y_q <= lfsr_y;
            idx_q    <= '0;
          end else if (idx_q == tail_count_q) begin
            apple_x_q <= cand_x_q;
            apple_y_q <= cand_y_q;
          end else begin
            idx_q <= idx_q + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign entity     = entity_q;
  assign tail_count = tail_count_q;
  assign game_over  = (state_q == StOver);
  assign game_won   = (state_q == StWon);
  assign busy       = (state_q != StRun) && (state_q != StOver) && (state_q != StWon);

endmodule

// File: tb/tb_snake_engine.sv
// Randomized bench for snake_engine: a queue-based game model predicts moves, growth,
// collisions, win and step latency; apples are located by a full grid scan.
module tb_snake_engine;

  localparam int          GW   = 40;
  localparam int          GH   = 30;
  localparam int          MT   = 6;
  localparam logic [15:0] SEED = 16'hACE1;

  localparam logic [1:0] LEFT = 2'd0, TOP = 2'd1, RIGHT = 2'd2, DOWN = 2'd3;
  localparam int E_NONE = 0, E_HEAD = 1, E_TAIL = 2, E_APPLE = 3;

  logic       clk = 1'b0, reset_n = 1'b0, tick = 1'b0, dir_valid = 1'b0;
  logic [1:0] dir_in = 2'd0;
  logic [9:0] x_in = 10'd0, y_in = 10'd0;
  logic [1:0] entity;
  logic       game_over, game_won, busy;
  logic [$clog2(MT+1)-1:0] tail_count;

  int checks = 0;
  int errors = 0;

  snake_engine #(
    .GRID_W(GW), .GRID_H(GH), .H_SQUARE(16), .V_SQUARE(16), .MAX_TAILS(MT), .LFSR_SEED(SEED)
  ) dut (
    .vga_clk(clk), .reset_n(reset_n), .tick(tick), .dir_in(dir_in), .dir_valid(dir_valid),
    .x_in(x_in), .y_in(y_in), .entity(entity), .game_over(game_over), .game_won(game_won),
    .tail_count(tail_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference LFSR history, one entry per clock since the last reset.
  logic [15:0] m_lfsr;
  logic [15:0] lfsr_hist[$];
  always @(posedge clk) begin
    if (!reset_n) begin
      m_lfsr <= SEED;
      lfsr_hist.delete();
    end else begin
      lfsr_hist.push_back(m_lfsr);
      m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
  end

  // Game model
  int         hx, hy, ax, ay, tc;
  logic [1:0] cur_d, pend_d;
  int         bx[$], by[$];
  bit         over, won;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    hx = GW / 2; hy = GH / 2; ax = GW / 2 + GW / 4; ay = GH / 2; tc = 0;
    cur_d = RIGHT; pend_d = RIGHT; over = 0; won = 0;
    bx.delete(); by.delete();
  endfunction

  function automatic int model_ent(input int cx, input int cy);
    if (cx >= GW || cy >= GH) return E_NONE;
    if (cx == hx && cy == hy) return E_HEAD;
    if (cx == ax && cy == ay) return E_APPLE;
    foreach (bx[i]) if (bx[i] == cx && by[i] == cy) return E_TAIL;
    return E_NONE;
  endfunction

  function automatic logic [1:0] steer();
    logic [1:0] d;
    if (ax != hx) d = (ax > hx) ? RIGHT : LEFT;
    else          d = (ay > hy) ? DOWN : TOP;
    if (d == (cur_d ^ 2'b10)) d = cur_d ^ 2'b01;
    return d;
  endfunction

  task automatic query_cell(input int cx, input int cy, output logic [1:0] e);
    x_in = 10'(cx * 16 + int'($urandom_range(0, 15)));
    y_in = 10'(cy * 16 + int'($urandom_range(0, 15)));
    @(posedge clk); #1;
    e = entity;
  endtask

  task automatic request(input logic [1:0] d);
    dir_valid = 1'b1;
    dir_in    = d;
    @(posedge clk); #1;
    dir_valid = 1'b0;
    if (d != (cur_d ^ 2'b10)) pend_d = d;
  endtask

  task automatic check_state();
    logic [1:0] e;
    int k, cx, cy;
    check("tail_count", int'(tail_count), tc);
    check("game_over", int'(game_over), int'(over));
    check("game_won", int'(game_won), int'(won));
    check("busy_idle", int'(busy), 0);
    query_cell(hx, hy, e);
    check("head_cell", int'(e), E_HEAD);
    query_cell(ax, ay, e);
    check("apple_cell", int'(e), model_ent(ax, ay));
    if (tc > 0) begin
      k = int'($urandom_range(0, tc - 1));
      query_cell(bx[k], by[k], e);
      check("body_cell", int'(e), model_ent(bx[k], by[k]));
    end
    cx = int'($urandom_range(0, GW - 1));
    cy = int'($urandom_range(0, GH - 1));
    query_cell(cx, cy, e);
    check("rand_cell", int'(e), model_ent(cx, cy));
    cx = int'($urandom_range(GW, 63));
    cy = int'($urandom_range(0, 63));
    query_cell(cx, cy, e);
    check("off_grid", int'(e), E_NONE);
  endtask

  task automatic find_apple(input int w0, input int w1);
    logic [1:0] e;
    int napple, on_snake, found, lo, hi;
    napple = 0;
    for (int cy = 0; cy < GH; cy++) begin
      for (int cx = 0; cx < GW; cx++) begin
        query_cell(cx, cy, e);
        if (int'(e) == E_APPLE) begin
          napple++;
          ax = cx;
          ay = cy;
        end else begin
          check("scan_cell", int'(e), (model_ent(cx, cy) == E_APPLE) ? E_NONE : model_ent(cx, cy));
        end
      end
    end
    check("apple_count", napple, 1);
    on_snake = (ax == hx && ay == hy) ? 1 : 0;
    foreach (bx[i]) if (bx[i] == ax && by[i] == ay) on_snake = 1;
    check("apple_free", on_snake, 0);
    found = 0;
    lo = (w0 > 2) ? w0 - 2 : 0;
    hi = (w1 + 2 < lfsr_hist.size()) ? w1 + 2 : lfsr_hist.size() - 1;
    for (int k = lo; k <= hi; k++) begin
      if (int'(lfsr_hist[k][7:0]) % GW == ax && int'(lfsr_hist[k][15:8]) % GH == ay) found = 1;
    end
    check("apple_lfsr", found, 1);
  endtask

  task automatic step(input int hold);
    logic [1:0] e;
    int nx, ny, hit, cnt, base, w0;
    bit done, eat;
    nx = hx; ny = hy;
    case (pend_d)
      LEFT:    nx = (hx == 0) ? GW - 1 : hx - 1;
      RIGHT:   nx = (hx + 1) % GW;
      TOP:     ny = (hy == 0) ? GH - 1 : hy - 1;
      default: ny = (hy + 1) % GH;
    endcase
    hit = -1;
    for (int i = 0; i < tc; i++) if (hit < 0 && bx[i] == nx && by[i] == ny) hit = i;
    base = ((tc == 0) ? 1 : tc) + 1;
    w0   = lfsr_hist.size();
    tick = 1'b1;
    cnt  = 0;
    done = 0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      if (i == hold - 1) tick = 1'b0;
      if (!busy) begin
        done = 1;
        break;
      end
      cnt++;
    end
    tick = 1'b0;
    if (!done) check("busy_timeout", int'(busy), 0);
    if (hit >= 0) begin
      over = 1;
      check("over_latency", cnt, hit + 1);
      query_cell(nx, ny, e);
      check("over_no_move", int'(e), E_TAIL);
    end else begin
      eat = (nx == ax && ny == ay);
      bx.push_front(hx); by.push_front(hy);
      hx = nx; hy = ny; cur_d = pend_d;
      if (eat) tc++;
      else begin
        void'(bx.pop_back());
        void'(by.pop_back());
      end
      if (tc == MT) begin
        won = 1;
        check("won_latency", cnt, base);
      end else if (eat) begin
        check("place_latency_min", (cnt >= base + tc + 1) ? 1 : 0, 1);
        find_apple(w0, lfsr_hist.size());
      end else begin
        check("step_latency", cnt, base);
      end
    end
    check_state();
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    tick      = 1'b0;
    dir_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_entity", int'(entity), E_NONE);
    check("rst_busy", int'(busy), 0);
    reset_n = 1'b1;
    model_reset();
    check_state();
  endtask

  task automatic terminal_test();
    tick = 1'b1;
    @(posedge clk); #1;
    check("term_busy", int'(busy), 0);
    @(posedge clk); #1;
    tick = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic square_loop();
    logic [1:0] a, d0;
    d0 = cur_d;
    a  = d0 ^ 2'b01;
    request(a); step(1);
    if (!over && !won) begin request(d0 ^ 2'b10); step(1); end
    if (!over && !won) begin request(a ^ 2'b10); step(1); end
  endtask

  initial begin
    #(10 * 200000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] e;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    step(1);
    x_in = 10'd336;
    y_in = 10'd240;
    @(posedge clk); #1;
    check("px_336_240", int'(entity), E_HEAD);

    request(LEFT);  step(1);
    request(TOP);   step(1);
    request(RIGHT); repeat (18) step(1);
    query_cell(0, 14, e);
    check("wrap_x_head", int'(e), E_HEAD);
    request(TOP);   repeat (15) step(1);
    query_cell(0, 29, e);
    check("wrap_y_head", int'(e), E_HEAD);

    for (int ep = 0; ep < 4; ep++) begin
      do_reset();
      for (int s = 0; s < 300 && !over && !won; s++) begin
        if ((ep % 2 == 1) && tc >= 4) begin
          square_loop();
        end else begin
          if ($urandom_range(0, 3) == 0) request(2'($urandom_range(0, 3)));
          else                           request(steer());
          step((tc == 5) ? 3 : int'($urandom_range(1, 3)));
        end
      end
      if (over || won) terminal_test();
    end

    do_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
